// File: rtl/clock_pkg.sv
// Shared types and helpers for the BCD countdown timer: state encoding,
// the 59 constant, packed-BCD decrement and load validation.
package clock_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_e;

  localparam logic [7:0] BCD_59 = 8'h59;

  // One-step packed-BCD decrement; 00 stays 00, wrap is the caller's job.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v == 8'h00)        return 8'h00;
    else if (v[3:0] == '0) return {v[7:4] - 4'd1, 4'd9};
    else                   return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Packed-BCD ordering matches numeric ordering once digits are legal.
  function automatic logic load_ok(input logic [7:0] lm, input logic [7:0] ls,
                                   input logic [7:0] max_min);
    return (lm[7:4] <= 4'd9) && (lm[3:0] <= 4'd9) &&
           (ls[7:4] <= 4'd5) && (ls[3:0] <= 4'd9) && (lm <= max_min);
  endfunction

endpackage

// File: rtl/bcd_down60.sv
// 00-59 packed-BCD down-counter; borrow fires on the step that wraps 00 -> 59.
module bcd_down60
  import clock_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ld,
  input  logic [7:0] ld_val,
  output logic [7:0] cnt,
  output logic       borrow
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld)       cnt_d = ld_val;
    else if (en)  cnt_d = (cnt_q == 8'h00) ? BCD_59 : bcd_dec(cnt_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= 8'h00;
    else      cnt_q <= cnt_d;
  end

  assign cnt    = cnt_q;
  assign borrow = en && !ld && (cnt_q == 8'h00);

endmodule

// File: rtl/bcd_countdown.sv
// MM:SS countdown timer with load/start/pause control and a tick-timed alarm
// after expiry. Everything visible is registered.
module bcd_countdown
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX_MIN     = 8'h59,
  parameter int         ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic       busy,
  output logic       done,
  output logic       alarm
);

  localparam int ACW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS + 1) : 1;

  state_e           state_q, state_d;
  logic [7:0]       min_q, min_d;
  logic [ACW-1:0]   acnt_q, acnt_d;
  logic             busy_q, busy_d, done_q, done_d, alarm_q, alarm_d;
  logic [7:0]       sec_cnt;
  logic             sec_borrow;
  logic             ld_ok, ld_take, run_tick, expire;

  // A load outside RUN owns the cycle: valid captures, invalid freezes.
  assign ld_ok    = load_ok(load_min, load_sec, MAX_MIN);
  assign ld_take  = load && (state_q != ST_RUN) && ld_ok;
  assign run_tick = (state_q == ST_RUN) && tick && !pause;
  assign expire   = run_tick && (min_q == 8'h00) && (sec_cnt == 8'h01);

  bcd_down60 u_sec (
    .clk    (clk),
    .rst    (rst),
    .en     (run_tick),
    .ld     (ld_take),
    .ld_val (load_sec),
    .cnt    (sec_cnt),
    .borrow (sec_borrow)
  );

  // next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_PAUSE: begin
        if (load) begin
          if (ld_ok) state_d = ST_IDLE;
        end else if (start && !pause && ({min_q, sec_cnt} != 16'h0000)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (pause)       state_d = ST_PAUSE;
        else if (expire) state_d = ST_DONE;
      end
      ST_DONE: if (ld_take) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // datapath and registered outputs
  always_comb begin
    min_d = min_q;
    if (ld_take)         min_d = load_min;
    else if (sec_borrow) min_d = bcd_dec(min_q);

    acnt_d = acnt_q;
    if (ld_take)
      acnt_d = '0;
    else if (expire)
      acnt_d = ACW'(ALARM_TICKS);
    else if ((state_q == ST_DONE) && tick && !load && (acnt_q != '0))
      acnt_d = acnt_q - 1'b1;

    busy_d  = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
    alarm_d = (acnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      min_q   <= 8'h00;
      acnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      acnt_q  <= acnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      alarm_q <= alarm_d;
    end
  end

  assign min   = min_q;
  assign sec   = sec_cnt;
  assign busy  = busy_q;
  assign done  = done_q;
  assign alarm = alarm_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// Bench for bcd_countdown: two instances (default and MAX_MIN=30/ALARM_TICKS=0)
// compared every cycle against a seconds-based behavioural model.
module tb_bcd_countdown;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick, load, start, pause;
  logic [7:0] load_min, load_sec;
  logic [7:0] min_a, sec_a, min_b, sec_b;
  logic       busy_a, done_a, alarm_a, busy_b, done_b, alarm_b;

  always #5 clk = ~clk;

  bcd_countdown u_a (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .load_min(load_min),
    .load_sec(load_sec), .start(start), .pause(pause),
    .min(min_a), .sec(sec_a), .busy(busy_a), .done(done_a), .alarm(alarm_a)
  );

  bcd_countdown #(.MAX_MIN(8'h30), .ALARM_TICKS(0)) u_b (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .load_min(load_min),
    .load_sec(load_sec), .start(start), .pause(pause),
    .min(min_b), .sec(sec_b), .busy(busy_b), .done(done_b), .alarm(alarm_b)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // model: remaining time in plain seconds, mode as a small integer
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int mt[2], mmode[2], marem[2];
  int maxm[2] = '{59, 30};
  int atk[2]  = '{10, 0};

  function automatic logic [7:0] i2bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mt[k] = 0; mmode[k] = M_IDLE; marem[k] = 0;
    end
  endtask

  task automatic model_step();
    int lm_t, lm_u, ls_t, ls_u;
    bit valid;
    lm_t = int'(load_min[7:4]); lm_u = int'(load_min[3:0]);
    ls_t = int'(load_sec[7:4]); ls_u = int'(load_sec[3:0]);
    for (int k = 0; k < 2; k++) begin
      valid = (lm_t <= 9) && (lm_u <= 9) && (ls_t <= 5) && (ls_u <= 9) &&
              (lm_t * 10 + lm_u <= maxm[k]);
      if (mmode[k] != M_RUN && load) begin
        if (valid) begin
          mt[k] = (lm_t * 10 + lm_u) * 60 + ls_t * 10 + ls_u;
          mmode[k] = M_IDLE; marem[k] = 0;
        end
      end else if (mmode[k] == M_RUN) begin
        if (pause) mmode[k] = M_PAUSE;
        else if (tick) begin
          mt[k]--;
          if (mt[k] == 0) begin mmode[k] = M_DONE; marem[k] = atk[k]; end
        end
      end else if (mmode[k] == M_DONE) begin
        if (tick && marem[k] > 0) marem[k]--;
      end else if (start && !pause && mt[k] != 0) begin
        mmode[k] = M_RUN;
      end
    end
  endtask

  task automatic check_all(input string w);
    chk({w, ".min_a"},   32'(min_a),   32'(i2bcd(mt[0] / 60)));
    chk({w, ".sec_a"},   32'(sec_a),   32'(i2bcd(mt[0] % 60)));
    chk({w, ".busy_a"},  32'(busy_a),  32'(mmode[0] == M_RUN));
    chk({w, ".done_a"},  32'(done_a),  32'(mmode[0] == M_DONE));
    chk({w, ".alarm_a"}, 32'(alarm_a), 32'(marem[0] > 0));
    chk({w, ".min_b"},   32'(min_b),   32'(i2bcd(mt[1] / 60)));
    chk({w, ".sec_b"},   32'(sec_b),   32'(i2bcd(mt[1] % 60)));
    chk({w, ".busy_b"},  32'(busy_b),  32'(mmode[1] == M_RUN));
    chk({w, ".done_b"},  32'(done_b),  32'(mmode[1] == M_DONE));
    chk({w, ".alarm_b"}, 32'(alarm_b), 32'(marem[1] > 0));
  endtask

  task automatic cyc(input string w, input bit ld, input logic [7:0] lm,
                     input logic [7:0] ls, input bit st, input bit pa, input bit tk);
    @(negedge clk);
    load = ld; load_min = lm; load_sec = ls; start = st; pause = pa; tick = tk;
    @(posedge clk);
    model_step();
    #1;
    check_all(w);
    load = 0; start = 0; pause = 0; tick = 0;
  endtask

  task automatic ticks(input string w, input int n);
    for (int i = 0; i < n; i++) cyc(w, 0, 8'h00, 8'h00, 0, 0, 1);
  endtask

  initial begin
    rst = 0; tick = 0; load = 0; start = 0; pause = 0;
    load_min = 8'h00; load_sec = 8'h00;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk); rst = 1;

    // invalid loads and start at 00:00
    cyc("start00", 0, 8'h00, 8'h00, 1, 0, 1);
    chk("start00.busy", 32'(busy_a), 32'd0);
    cyc("ld1A", 1, 8'h1A, 8'h00, 0, 0, 0);
    cyc("ld_sec60", 1, 8'h01, 8'h60, 0, 0, 0);
    chk("ld_sec60.min", 32'(min_a), 32'h00);
    cyc("ld_b_over", 1, 8'h31, 8'h00, 0, 0, 0);

    // 01:00 -> 00:59
    cyc("ld0100", 1, 8'h01, 8'h00, 0, 0, 0);
    cyc("st0100", 0, 8'h00, 8'h00, 1, 0, 0);
    ticks("t0100", 1);
    chk("t0100.min", 32'(min_a), 32'h00);
    chk("t0100.sec", 32'(sec_a), 32'h59);
    chk("t0100.busy", 32'(busy_a), 32'd1);
    cyc("pz0100", 0, 8'h00, 8'h00, 0, 1, 0);

    // 00:10 expiry and alarm window
    cyc("ld0010", 1, 8'h00, 8'h10, 0, 0, 0);
    cyc("st0010", 0, 8'h00, 8'h00, 1, 0, 0);
    ticks("t0010", 1);
    chk("t0010.sec", 32'(sec_a), 32'h09);
    ticks("t0010b", 9);
    chk("exp.done", 32'(done_a), 32'd1);
    chk("exp.alarm", 32'(alarm_a), 32'd1);
    chk("exp.alarm_b", 32'(alarm_b), 32'd0);
    cyc("done_st", 0, 8'h00, 8'h00, 1, 1, 0);
    ticks("alm", 9);
    chk("alm9.alarm", 32'(alarm_a), 32'd1);
    ticks("alm10", 1);
    chk("alm10.alarm", 32'(alarm_a), 32'd0);
    chk("alm10.done", 32'(done_a), 32'd1);

    // pause/resume around 02:30
    cyc("ld0231", 1, 8'h02, 8'h31, 0, 0, 0);
    cyc("st0231", 0, 8'h00, 8'h00, 1, 0, 0);
    ticks("t0231", 1);
    cyc("pz_tk", 0, 8'h00, 8'h00, 0, 1, 1);
    ticks("pz_hold", 5);
    chk("pz_hold.sec", 32'(sec_a), 32'h30);
    cyc("resume", 0, 8'h00, 8'h00, 1, 0, 0);
    ticks("t0229", 1);
    chk("t0229.sec", 32'(sec_a), 32'h29);

    // load+start together, then DONE cleared by a load
    cyc("ld_run", 1, 8'h00, 8'h05, 0, 0, 1);
    cyc("pz2", 0, 8'h00, 8'h00, 0, 1, 0);
    cyc("ldst", 1, 8'h00, 8'h01, 1, 0, 0);
    chk("ldst.busy", 32'(busy_a), 32'd0);
    cyc("st0001", 0, 8'h00, 8'h00, 1, 0, 0);
    ticks("t0001", 1);
    cyc("ld_done", 1, 8'h00, 8'h05, 0, 0, 0);
    chk("ld_done.done", 32'(done_a), 32'd0);
    chk("ld_done.alarm", 32'(alarm_a), 32'd0);

    // asynchronous reset mid-run at 12:34
    cyc("ld1234", 1, 8'h12, 8'h34, 0, 0, 0);
    cyc("st1234", 0, 8'h00, 8'h00, 1, 0, 0);
    #2;
    rst = 0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk); rst = 1;

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] lm, ls;
      bit ld, st, pa, tk;
      if ($urandom_range(0, 7) == 0) begin
        lm = 8'($urandom); ls = 8'($urandom);
      end else begin
        lm = ($urandom_range(0, 2) == 0) ? 8'h00 : i2bcd($urandom_range(0, 40));
        ls = i2bcd($urandom_range(0, 12) == 0 ? $urandom_range(0, 59) : $urandom_range(0, 3));
      end
      ld = ($urandom_range(0, 15) == 0);
      st = ($urandom_range(0, 5) == 0);
      pa = ($urandom_range(0, 19) == 0);
      tk = ($urandom_range(0, 1) == 0);
      cyc("rnd", ld, lm, ls, st, pa, tk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
